// File: rtl/fft_bf_sched.sv
// Address and strobe sequencer for an in-place radix-2 DIT FFT.
// For each stage it issues one butterfly read per cycle, then idles long
// enough for the butterfly pipeline to write back before the next stage
// reads. Write addresses and strobes are the read ones delayed by
// BF_LATENCY cycles.
//
//  state   | meaning
//  --------+-----------------------------------------------------------
//  S_IDLE  | waiting for start; outputs quiet, stage holds last value
//  S_RUN   | one butterfly read per cycle, j = 0 .. N/2-1
//  S_DRAIN | no reads for BF_LATENCY cycles while writes land
//  S_DONE  | one-cycle done pulse, then back to S_IDLE
module fft_bf_sched #(
    parameter int LOG2N      = 3,
    parameter int BF_LATENCY = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    output logic             rd_en,
    output logic [LOG2N-1:0] rd_addr_a,
    output logic [LOG2N-1:0] rd_addr_b,
    output logic [LOG2N-2:0] tw_idx,
    output logic             wr_en,
    output logic [LOG2N-1:0] wr_addr_a,
    output logic [LOG2N-1:0] wr_addr_b,
    output logic [4:0]       stage,
    output logic             busy,
    output logic             done
);

    localparam int JW = LOG2N - 1;
    localparam int CW = (BF_LATENCY > 1) ? $clog2(BF_LATENCY) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t           state_q;
    logic [JW-1:0]    j_q;
    logic [JW-1:0]    j_d;
    logic [CW-1:0]    cnt_q;
    logic [4:0]       stage_q;
    logic [4:0]       stage_d;
    logic             rd_en_q;
    logic [LOG2N-1:0] rd_a_q;
    logic [LOG2N-1:0] rd_b_q;
    logic [JW-1:0]    tw_q;
    logic             busy_q;
    logic             done_q;

    logic             dly_en_q [BF_LATENCY];
    logic [LOG2N-1:0] dly_a_q  [BF_LATENCY];
    logic [LOG2N-1:0] dly_b_q  [BF_LATENCY];

    // Upper leg: block base (j >> s) * 2 * half plus offset j mod half.
    function automatic logic [LOG2N-1:0] leg_a(input logic [JW-1:0] j, input logic [4:0] s);
        logic [LOG2N-1:0] jw;
        logic [LOG2N-1:0] low_mask;
        jw       = {1'b0, j};
        low_mask = ~({LOG2N{1'b1}} << s);
        return ((jw >> s) << (s + 5'd1)) | (jw & low_mask);
    endfunction

    // Lower leg sits half = 2**s above the upper leg.
    function automatic logic [LOG2N-1:0] leg_b(input logic [JW-1:0] j, input logic [4:0] s);
        logic [LOG2N-1:0] half;
        half = {{(LOG2N-1){1'b0}}, 1'b1} << s;
        return leg_a(j, s) + half;
    endfunction

    // Twiddle exponent: offset within the block scaled to the N-point root.
    function automatic logic [JW-1:0] tw_of(input logic [JW-1:0] j, input logic [4:0] s);
        logic [LOG2N-1:0] jw;
        logic [LOG2N-1:0] low_mask;
        logic [LOG2N-1:0] t;
        jw       = {1'b0, j};
        low_mask = ~({LOG2N{1'b1}} << s);
        t        = (jw & low_mask) << (5'(LOG2N - 1) - s);
        return t[JW-1:0];
    endfunction

    assign j_d     = j_q + 1'b1;
    assign stage_d = stage_q + 5'd1;

    // Sequencing FSM with registered read-side outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            j_q     <= '0;
            cnt_q   <= '0;
            stage_q <= '0;
            rd_en_q <= 1'b0;
            rd_a_q  <= '0;
            rd_b_q  <= '0;
            tw_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else if (abort) begin
            // Cancel from any state; stage is left as it was.
            state_q <= S_IDLE;
            j_q     <= '0;
            cnt_q   <= '0;
            rd_en_q <= 1'b0;
            rd_a_q  <= '0;
            rd_b_q  <= '0;
            tw_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    done_q <= 1'b0;
                    busy_q <= 1'b0;
                    if (start) begin
                        state_q <= S_RUN;
                        stage_q <= '0;
                        j_q     <= '0;
                        rd_en_q <= 1'b1;
                        rd_a_q  <= leg_a('0, 5'd0);
                        rd_b_q  <= leg_b('0, 5'd0);
                        tw_q    <= tw_of('0, 5'd0);
                        busy_q  <= 1'b1;
                    end
                end
                S_RUN: begin
                    if (j_q == '1) begin
                        state_q <= S_DRAIN;
                        rd_en_q <= 1'b0;
                        rd_a_q  <= '0;
                        rd_b_q  <= '0;
                        tw_q    <= '0;
                        cnt_q   <= CW'(BF_LATENCY - 1);
                    end else begin
                        j_q    <= j_d;
                        rd_a_q <= leg_a(j_d, stage_q);
                        rd_b_q <= leg_b(j_d, stage_q);
                        tw_q   <= tw_of(j_d, stage_q);
                    end
                end
                S_DRAIN: begin
                    if (cnt_q == '0) begin
                        if (stage_q == 5'(LOG2N - 1)) begin
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= S_RUN;
                            stage_q <= stage_d;
                            j_q     <= '0;
                            rd_en_q <= 1'b1;
                            rd_a_q  <= leg_a('0, stage_d);
                            rd_b_q  <= leg_b('0, stage_d);
                            tw_q    <= tw_of('0, stage_d);
                        end
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // Write-back delay line; abort flushes it so no stale write escapes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < BF_LATENCY; i++) begin
                dly_en_q[i] <= 1'b0;
                dly_a_q[i]  <= '0;
                dly_b_q[i]  <= '0;
            end
        end else if (abort) begin
            for (int i = 0; i < BF_LATENCY; i++) begin
                dly_en_q[i] <= 1'b0;
                dly_a_q[i]  <= '0;
                dly_b_q[i]  <= '0;
            end
        end else begin
            dly_en_q[0] <= rd_en_q;
            dly_a_q[0]  <= rd_a_q;
            dly_b_q[0]  <= rd_b_q;
            for (int i = 1; i < BF_LATENCY; i++) begin
                dly_en_q[i] <= dly_en_q[i-1];
                dly_a_q[i]  <= dly_a_q[i-1];
                dly_b_q[i]  <= dly_b_q[i-1];
            end
        end
    end

    assign rd_en     = rd_en_q;
    assign rd_addr_a = rd_a_q;
    assign rd_addr_b = rd_b_q;
    assign tw_idx    = tw_q;
    assign wr_en     = dly_en_q[BF_LATENCY-1];
    assign wr_addr_a = dly_a_q[BF_LATENCY-1];
    assign wr_addr_b = dly_b_q[BF_LATENCY-1];
    assign stage     = stage_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_fft_bf_sched.sv
// Bench for fft_bf_sched: an N=8/L=3 instance and an N=16/L=1 instance,
// checked cycle by cycle against an arithmetic model of the butterfly order.
module tb_fft_bf_sched;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int sel      = 0;

    // Instance 0: LOG2N=3, BF_LATENCY=3
    logic       s8_start, s8_abort, s8_rstn;
    logic       r8_en, w8_en, busy8, done8;
    logic [2:0] r8_a, r8_b, w8_a, w8_b;
    logic [1:0] r8_tw;
    logic [4:0] st8;

    // Instance 1: LOG2N=4, BF_LATENCY=1
    logic       s16_start, s16_abort, s16_rstn;
    logic       r16_en, w16_en, busy16, done16;
    logic [3:0] r16_a, r16_b, w16_a, w16_b;
    logic [2:0] r16_tw;
    logic [4:0] st16;

    fft_bf_sched #(.LOG2N(3), .BF_LATENCY(3)) dut8 (
        .clk(clk), .rst_n(s8_rstn), .start(s8_start), .abort(s8_abort),
        .rd_en(r8_en), .rd_addr_a(r8_a), .rd_addr_b(r8_b), .tw_idx(r8_tw),
        .wr_en(w8_en), .wr_addr_a(w8_a), .wr_addr_b(w8_b),
        .stage(st8), .busy(busy8), .done(done8)
    );

    fft_bf_sched #(.LOG2N(4), .BF_LATENCY(1)) dut16 (
        .clk(clk), .rst_n(s16_rstn), .start(s16_start), .abort(s16_abort),
        .rd_en(r16_en), .rd_addr_a(r16_a), .rd_addr_b(r16_b), .tw_idx(r16_tw),
        .wr_en(w16_en), .wr_addr_a(w16_a), .wr_addr_b(w16_b),
        .stage(st16), .busy(busy16), .done(done16)
    );

    logic        o_rd_en, o_wr_en, o_busy, o_done;
    logic [15:0] o_ra, o_rb, o_tw, o_wa, o_wb;
    logic [4:0]  o_stage;

    always_comb begin
        if (sel == 0) begin
            o_rd_en = r8_en;  o_ra = 16'(r8_a);  o_rb = 16'(r8_b);  o_tw = 16'(r8_tw);
            o_wr_en = w8_en;  o_wa = 16'(w8_a);  o_wb = 16'(w8_b);
            o_stage = st8;    o_busy = busy8;    o_done = done8;
        end else begin
            o_rd_en = r16_en; o_ra = 16'(r16_a); o_rb = 16'(r16_b); o_tw = 16'(r16_tw);
            o_wr_en = w16_en; o_wa = 16'(w16_a); o_wb = 16'(w16_b);
            o_stage = st16;   o_busy = busy16;   o_done = done16;
        end
    end

    function automatic int lg_of(input int s);
        return (s == 0) ? 3 : 4;
    endfunction

    function automatic int lat_of(input int s);
        return (s == 0) ? 3 : 1;
    endfunction

    // Reference: cycle p after the first read, from the butterfly definition.
    function automatic void exp_rd(input int lg, input int lat, input int p,
                                   output logic en, output int a, output int b,
                                   output int tw, output int stg);
        int n2, per, r, j, half;
        n2  = (1 << lg) / 2;
        per = n2 + lat;
        stg = p / per;
        r   = p % per;
        en  = (r < n2);
        a = 0; b = 0; tw = 0;
        if (en) begin
            j    = r;
            half = 1 << stg;
            a    = (j / half) * 2 * half + (j % half);
            b    = a + half;
            tw   = (j % half) * (1 << (lg - 1 - stg));
        end
    endfunction

    task automatic set_in(input logic st, input logic ab);
        if (sel == 0) begin s8_start = st;  s8_abort = ab;  end
        else          begin s16_start = st; s16_abort = ab; end
    endtask

    task automatic set_rst(input logic v);
        if (sel == 0) s8_rstn = v;
        else          s16_rstn = v;
    endtask

    task automatic test_reset();
        for (int s = 0; s < 2; s++) begin
            sel = s;
            #1;
            checks++;
            if ({o_rd_en, o_ra, o_rb, o_tw, o_wr_en, o_wa, o_wb, o_stage, o_busy, o_done} !== '0) begin
                failures++;
                $display("FAIL reset_state dut%0d rd_en=%b wr_en=%b stage=%0d busy=%b done=%b required all 0",
                         s, o_rd_en, o_wr_en, o_stage, o_busy, o_done);
            end
        end
        @(negedge clk);
        s8_rstn = 1'b1;
        s16_rstn = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_transform(input int s, input bit hold, input bit rnd_start);
        int lg, lat, n2, per, tot, gap;
        logic e_en, w_en;
        int ea, eb, et, es, wa, wb, wt, ws;
        logic [48:0] obs, exv;
        logic [32:0] wobs, wexv;
        sel = s;
        #1;
        lg = lg_of(s); lat = lat_of(s);
        n2 = (1 << lg) / 2; per = n2 + lat; tot = lg * per;
        gap = $urandom_range(0, 3);
        for (int g = 0; g < gap; g++) begin
            checks++;
            if (o_busy !== 1'b0 || o_rd_en !== 1'b0) begin
                failures++;
                $display("FAIL idle_gap dut%0d busy=%b rd_en=%b required 0 0", s, o_busy, o_rd_en);
            end
            @(negedge clk);
        end
        set_in(1'b1, 1'b0);
        @(negedge clk);
        for (int c = 0; c < tot; c++) begin
            exp_rd(lg, lat, c, e_en, ea, eb, et, es);
            obs = {o_rd_en, e_en ? o_ra : 16'd0, e_en ? o_rb : 16'd0, e_en ? o_tw : 16'd0};
            exv = {e_en, 16'(ea), 16'(eb), 16'(et)};
            checks++;
            if (obs !== exv) begin
                failures++;
                $display("FAIL rd_seq dut%0d c=%0d got en=%b a=%0d b=%0d tw=%0d required en=%b a=%0d b=%0d tw=%0d",
                         s, c, o_rd_en, o_ra, o_rb, o_tw, e_en, ea, eb, et);
            end
            if (c >= lat) exp_rd(lg, lat, c - lat, w_en, wa, wb, wt, ws);
            else begin w_en = 1'b0; wa = 0; wb = 0; end
            wobs = {o_wr_en, w_en ? o_wa : 16'd0, w_en ? o_wb : 16'd0};
            wexv = {w_en, 16'(wa), 16'(wb)};
            checks++;
            if (wobs !== wexv) begin
                failures++;
                $display("FAIL wr_seq dut%0d c=%0d got en=%b a=%0d b=%0d required en=%b a=%0d b=%0d",
                         s, c, o_wr_en, o_wa, o_wb, w_en, wa, wb);
            end
            checks++;
            if ({o_stage, o_busy, o_done} !== {5'(es), 1'b1, 1'b0}) begin
                failures++;
                $display("FAIL run_status dut%0d c=%0d got stage=%0d busy=%b done=%b required stage=%0d busy=1 done=0",
                         s, c, o_stage, o_busy, o_done, es);
            end
            set_in(hold ? 1'b1 : (rnd_start ? 1'($urandom_range(0, 1)) : 1'b0), 1'b0);
            @(negedge clk);
        end
        checks++;
        if ({o_done, o_busy, o_rd_en, o_wr_en, o_stage} !== {1'b1, 1'b1, 1'b0, 1'b0, 5'(lg - 1)}) begin
            failures++;
            $display("FAIL done_pulse dut%0d got done=%b busy=%b rd_en=%b wr_en=%b stage=%0d required 1 1 0 0 %0d",
                     s, o_done, o_busy, o_rd_en, o_wr_en, o_stage, lg - 1);
        end
        set_in(1'b0, 1'b0);
        @(negedge clk);
        checks++;
        if ({o_done, o_busy, o_rd_en, o_stage} !== {1'b0, 1'b0, 1'b0, 5'(lg - 1)}) begin
            failures++;
            $display("FAIL post_done dut%0d got done=%b busy=%b rd_en=%b stage=%0d required 0 0 0 %0d",
                     s, o_done, o_busy, o_rd_en, o_stage, lg - 1);
        end
        @(negedge clk);
        checks++;
        if ({o_busy, o_rd_en} !== 2'b00) begin
            failures++;
            $display("FAIL no_restart dut%0d got busy=%b rd_en=%b required 0 0", s, o_busy, o_rd_en);
        end
    endtask

    task automatic test_abort(input int s, input int c_ab);
        int lg, lat, n2;
        sel = s;
        #1;
        lg = lg_of(s); lat = lat_of(s); n2 = (1 << lg) / 2;
        set_in(1'b1, 1'b0);
        @(negedge clk);
        for (int c = 0; c < c_ab; c++) begin
            set_in(1'b0, 1'b0);
            @(negedge clk);
        end
        set_in(1'b0, 1'b1);
        @(negedge clk);
        checks++;
        if ({o_rd_en, o_wr_en, o_busy, o_done} !== 4'b0000) begin
            failures++;
            $display("FAIL abort_next dut%0d at=%0d got rd_en=%b wr_en=%b busy=%b done=%b required 0 0 0 0",
                     s, c_ab, o_rd_en, o_wr_en, o_busy, o_done);
        end
        set_in(1'b0, 1'b0);
        for (int k = 0; k < n2 + lat + 2; k++) begin
            @(negedge clk);
            checks++;
            if ({o_rd_en, o_wr_en, o_busy, o_done} !== 4'b0000) begin
                failures++;
                $display("FAIL abort_quiet dut%0d k=%0d got rd_en=%b wr_en=%b busy=%b done=%b required 0 0 0 0",
                         s, k, o_rd_en, o_wr_en, o_busy, o_done);
            end
        end
        test_transform(s, 1'b0, 1'b1);
    endtask

    task automatic test_abort_with_start(input int s);
        sel = s;
        #1;
        set_in(1'b1, 1'b1);
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            checks++;
            if ({o_rd_en, o_busy} !== 2'b00) begin
                failures++;
                $display("FAIL abort_start dut%0d k=%0d got rd_en=%b busy=%b required 0 0", s, k, o_rd_en, o_busy);
            end
            set_in(1'b0, 1'b0);
        end
    endtask

    task automatic test_reset_mid(input int s);
        int lg, lat, n2, c_r, wa, wb, wt, ws;
        logic w_en;
        sel = s;
        #1;
        lg = lg_of(s); lat = lat_of(s); n2 = (1 << lg) / 2;
        c_r = n2 + $urandom_range(0, lat - 1);
        set_in(1'b1, 1'b0);
        @(negedge clk);
        for (int c = 0; c < c_r; c++) begin
            set_in(1'b0, 1'b0);
            @(negedge clk);
        end
        exp_rd(lg, lat, c_r - lat, w_en, wa, wb, wt, ws);
        checks++;
        if (o_wr_en !== w_en) begin
            failures++;
            $display("FAIL pre_reset_wr dut%0d c=%0d got wr_en=%b required %b", s, c_r, o_wr_en, w_en);
        end
        #2;
        set_rst(1'b0);
        #1;
        checks++;
        if ({o_rd_en, o_ra, o_rb, o_tw, o_wr_en, o_wa, o_wb, o_stage, o_busy, o_done} !== '0) begin
            failures++;
            $display("FAIL reset_async dut%0d got rd_en=%b wr_en=%b stage=%0d busy=%b done=%b required all 0",
                     s, o_rd_en, o_wr_en, o_stage, o_busy, o_done);
        end
        @(negedge clk);
        set_rst(1'b1);
        for (int k = 0; k < lat + 3; k++) begin
            @(negedge clk);
            checks++;
            if ({o_rd_en, o_wr_en, o_busy, o_done} !== 4'b0000) begin
                failures++;
                $display("FAIL reset_quiet dut%0d k=%0d got rd_en=%b wr_en=%b busy=%b done=%b required 0 0 0 0",
                         s, k, o_rd_en, o_wr_en, o_busy, o_done);
            end
        end
    endtask

    initial begin
        s8_rstn = 1'b0;  s8_start = 1'b0;  s8_abort = 1'b0;
        s16_rstn = 1'b0; s16_start = 1'b0; s16_abort = 1'b0;
        repeat (2) @(negedge clk);
        test_reset();
        test_transform(0, 1'b0, 1'b0);
        test_transform(0, 1'b1, 1'b0);
        test_transform(0, 1'b0, 1'b1);
        test_transform(1, 1'b0, 1'b1);
        test_abort(0, 8);
        test_abort(1, $urandom_range(0, 35));
        test_abort_with_start(0);
        test_abort_with_start(1);
        test_reset_mid(0);
        test_transform(0, 1'b0, 1'b1);
        test_reset_mid(1);
        test_transform(1, 1'b0, 1'b1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
